vregfile_seq: RTL

VREGFILE_SEQ -- requirements
Module: vregfile_seq

---
 rtl/vregfile_seq.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vregfile_seq.sv
// vregfile_seq: sequencer over a single-port vector register file.
//
// A request walks a register group (LMUL registers, or one register for
// fractional LMUL). For each register g it reads the source registers
// a/b/c (first num_operands_i of them) at base+g and, when we_i is set, the
// destination register at waddr_i+g. The register file has one port, so
// reads go out one per cycle. It then streams the active elements out one
// per handshake, merges each returned result element into rd, and writes rd
// back to waddr_i+g.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_i                   start request, sampled only in IDLE
//   busy_o                  high in every state except IDLE
//   num_operands_i, we_i    number of sources (0..3), destination write enable
//   raddr_{a,b,c}_i,waddr_i base register of each group
//   lmul_i, vl_i            group multiplier and active element count
//   rdata_{a,b,c}_o         current source elements (zero when not valid)
//   elem_valid_o/elem_ready_i, wdata_i   element stream and result element
//   vector_done_o           one-cycle pulse after the last register is done
//
// Element handshake: an element transfers on a rising clk_i edge where
// elem_valid_o && elem_ready_i. Once elem_valid_o is high, it and
// rdata_*_o stay unchanged until that transfer; elem_valid_o never depends
// on elem_ready_i.

package vcve2_pkg;
  typedef enum logic [2:0] {
    LMUL_1    = 3'b000,
    LMUL_2    = 3'b001,
    LMUL_4    = 3'b010,
    LMUL_8    = 3'b011,
    LMUL_RSVD = 3'b100,
    LMUL_F8   = 3'b101,
    LMUL_F4   = 3'b110,
    LMUL_F2   = 3'b111
  } vlmul_e;
endpackage

// Single-port RAM, registered read (data valid the cycle after the access).
module ram_1p #(
  parameter int Width = 128,
  parameter int Depth = 32
) (
  input  logic                     clk_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o
);
  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (req_i && we_i) mem[addr_i] <= wdata_i;
    if (req_i && !we_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module vregfile_seq
  import vcve2_pkg::*;
#(
  parameter int VLEN      = 128,
  parameter int ELEN      = 32,
  parameter int AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 busy_o,
  input  logic [1:0]           num_operands_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] raddr_a_i,
  input  logic [AddrWidth-1:0] raddr_b_i,
  input  logic [AddrWidth-1:0] raddr_c_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  vlmul_e               lmul_i,
  input  logic [9:0]           vl_i,
  output logic [ELEN-1:0]      rdata_a_o,
  output logic [ELEN-1:0]      rdata_b_o,
  output logic [ELEN-1:0]      rdata_c_o,
  output logic                 elem_valid_o,
  input  logic                 elem_ready_i,
  input  logic [ELEN-1:0]      wdata_i,
  output logic                 vector_done_o
);
  localparam int Count = VLEN / ELEN;
  localparam int EW    = $clog2(Count) + 1;  // holds 0..Count

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, RD_D, STREAM, WRITE} state_e;

  state_e              state_q, state_d;
  vlmul_e              lmul_q, lmul_d;
  logic [9:0]          vl_q, vl_d;
  logic [2:0]          regs_left_q, regs_left_d;
  logic [2:0]          g_q, g_d;
  logic [EW-1:0]       e_q, e_d;
  logic [VLEN-1:0]     rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d, rd_q, rd_d;
  logic                ld_valid_q, ld_valid_d;  // RAM output is pending for a register
  logic [1:0]          ld_sel_q, ld_sel_d;      // 0:rs1 1:rs2 2:rs3 3:rd
  logic                done_q, done_d;

  logic                ram_req, ram_we;
  logic [AddrWidth-1:0] ram_addr;
  logic [VLEN-1:0]     ram_rdata;
  logic [VLEN-1:0]     rs1_cur, rs2_cur, rs3_cur, rd_cur;
  logic [EW-1:0]       vc, active;
  logic [31:0]         vc_w, base_w, rem_w;
  logic [2:0]          regs_m1;
  logic [EW-2:0]       elem_idx;
  logic                hs;
  state_e              first_st, after_a, after_b, after_c;

  ram_1p #(.Width(VLEN), .Depth(2**AddrWidth)) u_ram (
    .clk_i   (clk_i),
    .req_i   (ram_req),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (rd_q),
    .rdata_o (ram_rdata)
  );

  // The last read of a register arrives during the first STREAM cycle, so
  // each register is viewed through a bypass from the RAM output.
  assign rs1_cur = (ld_valid_q && ld_sel_q == 2'd0) ? ram_rdata : rs1_q;
  assign rs2_cur = (ld_valid_q && ld_sel_q == 2'd1) ? ram_rdata : rs2_q;
  assign rs3_cur = (ld_valid_q && ld_sel_q == 2'd2) ? ram_rdata : rs3_q;
  assign rd_cur  = (ld_valid_q && ld_sel_q == 2'd3) ? ram_rdata : rd_q;

  // Read sequence: a, b, c (first num_operands_i), then d when writing.
  always_comb begin
    after_c  = we_i ? RD_D : STREAM;
    after_b  = (num_operands_i == 2'd3) ? RD_C : after_c;
    after_a  = (num_operands_i >= 2'd2) ? RD_B : after_b;
    first_st = (num_operands_i != 2'd0) ? RD_A : after_c;
  end

  always_comb begin
    case (lmul_i)
      LMUL_2:  regs_m1 = 3'd1;
      LMUL_4:  regs_m1 = 3'd3;
      LMUL_8:  regs_m1 = 3'd7;
      default: regs_m1 = 3'd0;  // LMUL 1, fractional, reserved
    endcase
  end

  // Per-register valid count and active elements in register g.
  always_comb begin
    case (lmul_q)
      LMUL_F2: vc = EW'(Count >> 1);
      LMUL_F4: vc = EW'(Count >> 2);
      LMUL_F8: vc = EW'(Count >> 3);
      default: vc = EW'(Count);
    endcase
    vc_w   = 32'(vc);
    base_w = 32'(g_q) * vc_w;
    rem_w  = (32'(vl_q) > base_w) ? (32'(vl_q) - base_w) : 32'd0;
    active = (rem_w > vc_w) ? vc : rem_w[EW-1:0];
  end

  assign elem_idx     = e_q[EW-2:0];
  assign elem_valid_o = (state_q == STREAM) && (e_q < active);
  assign hs           = elem_valid_o && elem_ready_i;
  assign busy_o       = (state_q != IDLE);
  assign vector_done_o = done_q;
  assign rdata_a_o = elem_valid_o ? rs1_cur[elem_idx*ELEN +: ELEN] : '0;
  assign rdata_b_o = elem_valid_o ? rs2_cur[elem_idx*ELEN +: ELEN] : '0;
  assign rdata_c_o = elem_valid_o ? rs3_cur[elem_idx*ELEN +: ELEN] : '0;

  always_comb begin
    state_d     = state_q;
    lmul_d      = lmul_q;
    vl_d        = vl_q;
    regs_left_d = regs_left_q;
    g_d         = g_q;
    e_d         = e_q;
    rs1_d       = rs1_cur;
    rs2_d       = rs2_cur;
    rs3_d       = rs3_cur;
    rd_d        = rd_cur;
    ld_valid_d  = 1'b0;
    ld_sel_d    = ld_sel_q;
    done_d      = 1'b0;
    ram_req     = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          lmul_d      = lmul_i;
          vl_d        = vl_i;
          regs_left_d = regs_m1;
          g_d         = 3'd0;
          e_d         = '0;
          rs1_d       = '0;
          rs2_d       = '0;
          rs3_d       = '0;
          rd_d        = '0;  // stays zero for the whole group when we_i is clear
          state_d     = first_st;
        end
      end
      RD_A: begin
        ram_req    = 1'b1;
        ram_addr   = raddr_a_i + AddrWidth'(g_q);
        ld_valid_d = 1'b1;
        ld_sel_d   = 2'd0;
        state_d    = after_a;
      end
      RD_B: begin
        ram_req    = 1'b1;
        ram_addr   = raddr_b_i + AddrWidth'(g_q);
        ld_valid_d = 1'b1;
        ld_sel_d   = 2'd1;
        state_d    = after_b;
      end
      RD_C: begin
        ram_req    = 1'b1;
        ram_addr   = raddr_c_i + AddrWidth'(g_q);
        ld_valid_d = 1'b1;
        ld_sel_d   = 2'd2;
        state_d    = after_c;
      end
      RD_D: begin
        ram_req    = 1'b1;
        ram_addr   = waddr_i + AddrWidth'(g_q);
        ld_valid_d = 1'b1;
        ld_sel_d   = 2'd3;
        state_d    = STREAM;
      end
      STREAM: begin
        if (!elem_valid_o) begin
          state_d = WRITE;  // no active elements in this register
        end else if (hs) begin
          if (we_i) rd_d[elem_idx*ELEN +: ELEN] = wdata_i;
          e_d = e_q + EW'(1);
          if (e_d == active) state_d = WRITE;
        end
      end
      WRITE: begin
        ram_req  = we_i;
        ram_we   = we_i;
        ram_addr = waddr_i + AddrWidth'(g_q);
        if (regs_left_q != 3'd0) begin
          regs_left_d = regs_left_q - 3'd1;
          g_d         = g_q + 3'd1;
          e_d         = '0;
          state_d     = first_st;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      lmul_q      <= LMUL_1;
      vl_q        <= '0;
      regs_left_q <= '0;
      g_q         <= '0;
      e_q         <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs3_q       <= '0;
      rd_q        <= '0;
      ld_valid_q  <= 1'b0;
      ld_sel_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lmul_q      <= lmul_d;
      vl_q        <= vl_d;
      regs_left_q <= regs_left_d;
      g_q         <= g_d;
      e_q         <= e_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs3_q       <= rs3_d;
      rd_q        <= rd_d;
      ld_valid_q  <= ld_valid_d;
      ld_sel_q    <= ld_sel_d;
      done_q      <= done_d;
    end
  end
endmodule
